wb_gpio_bank: RTL and testbench

//  Parametrised Wishbone-classic slave GPIO controller for team project wrappers.

---
 rtl/wb_gpio_bank.sv | 128 ++++++++++++
 tb/tb_wb_gpio_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_bank.sv
// Wishbone-classic GPIO bank: OUT/OEB/IN/IE/IS/EDGE registers for up to 64 pads.
// Ack follows a hit by one cycle; a held strobe is re-accepted every second cycle.
module wb_gpio_bank #(
  parameter int          NUM_GPIO      = 38,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK     = 32'h0000_003F,
  parameter logic [63:0] RESERVED_MASK = 64'h1E
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oeb,
  output logic                irq
);

  localparam int            N   = NUM_GPIO;
  localparam logic [N-1:0]  RES = RESERVED_MASK[N-1:0];

  logic          r_ack;
  logic [31:0]   r_dat;
  logic [N-1:0]  r_out, r_oeb, r_ie, r_is, r_edge;
  logic [N-1:0]  r_sync1, r_sync2, r_prev;
  logic [1:0]    r_arm;

  logic          w_hit, w_wr;
  logic [3:0]    w_off;
  logic [2:0]    w_reg;
  logic [31:0]   w_bmask32, w_rdata;
  logic [63:0]   w_wmask64, w_wdat64, w_view64;
  logic [N-1:0]  w_wmask, w_wdat, w_rise, w_fall, w_set, w_clr;
  logic          w_unused_ok;

  assign w_hit = wbs_cyc_i & wbs_stb_i & ~r_ack &
                 ((wbs_adr_i & ~ADDR_MASK) == BASE_ADDR);
  assign w_wr  = w_hit & wbs_we_i;
  assign w_off = wbs_adr_i[5:2];
  assign w_reg = w_off[3:1];

  assign w_bmask32 = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  // Odd offsets address the upper 32 pads of each register pair.
  assign w_wmask64 = w_off[0] ? {w_bmask32, 32'h0} : {32'h0, w_bmask32};
  assign w_wdat64  = w_off[0] ? {wbs_dat_i, 32'h0} : {32'h0, wbs_dat_i};
  assign w_wmask   = w_wmask64[N-1:0];
  assign w_wdat    = w_wdat64[N-1:0];
  assign w_unused_ok = ^{w_wmask64, w_wdat64};

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;
  assign w_set  = (r_arm == 2'd3) ? ((r_edge & w_rise) | (~r_edge & w_fall)) : '0;
  assign w_clr  = (w_wr && w_reg == 3'd4) ? (w_wdat & w_wmask) : '0;

  always_comb begin
    w_view64 = 64'h0;
    case (w_reg)
      3'd0:    w_view64 = 64'(r_out);
      3'd1:    w_view64 = 64'(r_oeb);
      3'd2:    w_view64 = 64'(r_sync2);
      3'd3:    w_view64 = 64'(r_ie);
      3'd4:    w_view64 = 64'(r_is);
      3'd5:    w_view64 = 64'(r_edge);
      default: w_view64 = 64'h0;
    endcase
  end

  assign w_rdata = w_off[0] ? w_view64[63:32] : w_view64[31:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_hit;
      r_dat <= (w_hit && !wbs_we_i) ? w_rdata : 32'h0;
    end
  end

  // Reserved pads are forced at write time, so reads and pads see the same value.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_out  <= '0;
      r_oeb  <= '1;
      r_ie   <= '0;
      r_edge <= '0;
    end else if (w_wr) begin
      case (w_reg)
        3'd0: r_out  <= ((r_out  & ~w_wmask) | (w_wdat & w_wmask)) & ~RES;
        3'd1: r_oeb  <= ((r_oeb  & ~w_wmask) | (w_wdat & w_wmask)) | RES;
        3'd3: r_ie   <= ((r_ie   & ~w_wmask) | (w_wdat & w_wmask)) & ~RES;
        3'd5: r_edge <=  (r_edge & ~w_wmask) | (w_wdat & w_wmask);
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_arm   <= 2'd0;
      r_is    <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_arm != 2'd3)
        r_arm <= r_arm + 2'd1;
      r_is    <= (r_is & ~w_clr) | w_set;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign gpio_out  = r_out;
  assign gpio_oeb  = r_oeb;
  assign irq       = |(r_is & r_ie);

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Directed bench for wb_gpio_bank with default parameters (38 pads, base 0x3000_0000).
module tb_wb_gpio_bank;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic [37:0] gpio_in = '0;
  logic [37:0] gpio_out, gpio_oeb;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  logic        a1, a2;
  logic [31:0] rd;

  always #5 clk = ~clk;

  wb_gpio_bank dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oeb  (gpio_oeb),
    .irq       (irq)
  );

  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic ack1, output logic ack2,
                          output logic [31:0] data);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    @(posedge clk); #1;
    ack1 = ack; data = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    ack2 = ack;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", ack); end
    vectors++; if (rdat !== 32'h0) begin miscompares++; $display("FAIL reset_dat: got %h want 0", rdat); end
    vectors++; if (gpio_out !== 38'h0) begin miscompares++; $display("FAIL reset_out: got %h want 0", gpio_out); end
    vectors++; if (gpio_oeb !== 38'h3F_FFFF_FFFF) begin miscompares++; $display("FAIL reset_oeb: got %h want 3fffffffff", gpio_oeb); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_write_out();
    bus_xfer(1'b1, BASE + 32'h00, 4'hF, 32'hFFFF_FFFF, a1, a2, rd);
    vectors++; if (a1 !== 1'b1) begin miscompares++; $display("FAIL wr_out_ack: got %b want 1", a1); end
    vectors++; if (a2 !== 1'b0) begin miscompares++; $display("FAIL wr_out_ack_pulse: got %b want 0", a2); end
    vectors++; if (gpio_out[31:0] !== 32'hFFFF_FFE1) begin miscompares++; $display("FAIL out_lo: got %h want ffffffe1", gpio_out[31:0]); end
    bus_xfer(1'b1, BASE + 32'h08, 4'hF, 32'h0, a1, a2, rd);
    vectors++; if (a1 !== 1'b1) begin miscompares++; $display("FAIL wr_oeb_ack: got %b want 1", a1); end
    vectors++; if (gpio_oeb[31:0] !== 32'h0000_001E) begin miscompares++; $display("FAIL oeb_lo: got %h want 0000001e", gpio_oeb[31:0]); end
    bus_xfer(1'b0, BASE + 32'h00, 4'hF, 32'h0, a1, a2, rd);
    vectors++; if (rd !== 32'hFFFF_FFE1) begin miscompares++; $display("FAIL rd_out_lo: got %h want ffffffe1", rd); end
    bus_xfer(1'b1, BASE + 32'h04, 4'hF, 32'hFFFF_FFFF, a1, a2, rd);
    vectors++; if (gpio_out[37:32] !== 6'h3F) begin miscompares++; $display("FAIL out_hi_pads: got %h want 3f", gpio_out[37:32]); end
    bus_xfer(1'b0, BASE + 32'h04, 4'hF, 32'h0, a1, a2, rd);
    vectors++; if (rd !== 32'h0000_003F) begin miscompares++; $display("FAIL rd_out_hi: got %h want 0000003f", rd); end
  endtask

  task automatic test_read_map();
    do_reset();
    bus_xfer(1'b0, BASE + 32'h0C, 4'hF, 32'h0, a1, a2, rd);
    vectors++; if (a1 !== 1'b1) begin miscompares++; $display("FAIL rd_oeb_hi_ack: got %b want 1", a1); end
    vectors++; if (rd !== 32'h0000_003F) begin miscompares++; $display("FAIL rd_oeb_hi: got %h want 0000003f", rd); end
    bus_xfer(1'b1, BASE + 32'h34, 4'hF, 32'hFFFF_FFFF, a1, a2, rd);
    bus_xfer(1'b0, BASE + 32'h34, 4'hF, 32'h0, a1, a2, rd);
    vectors++; if (a1 !== 1'b1) begin miscompares++; $display("FAIL rd_off13_ack: got %b want 1", a1); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rd_off13: got %h want 0", rd); end
    bus_xfer(1'b0, 32'h3000_0100, 4'hF, 32'h0, a1, a2, rd);
    vectors++; if (a1 !== 1'b0 || a2 !== 1'b0) begin miscompares++; $display("FAIL miss_ack: got %b%b want 00", a1, a2); end
  endtask

  task automatic test_edge_irq();
    do_reset();
    repeat (4) @(posedge clk);
    bus_xfer(1'b1, BASE + 32'h28, 4'hF, 32'h80, a1, a2, rd);
    bus_xfer(1'b1, BASE + 32'h18, 4'hF, 32'h80, a1, a2, rd);
    @(negedge clk);
    gpio_in[7] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b want 0", irq); end
    @(posedge clk); #1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_at_3: got %b want 1", irq); end
    bus_xfer(1'b0, BASE + 32'h20, 4'hF, 32'h0, a1, a2, rd);
    vectors++; if (rd !== 32'h80) begin miscompares++; $display("FAIL is_lo: got %h want 00000080", rd); end
    bus_xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0, a1, a2, rd);
    vectors++; if (rd !== 32'h80) begin miscompares++; $display("FAIL in_lo: got %h want 00000080", rd); end
    bus_xfer(1'b1, BASE + 32'h20, 4'hF, 32'h80, a1, a2, rd);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_w1c: got %b want 0", irq); end
  endtask

  task automatic test_reset_hold();
    gpio_in[7] = 1'b1;
    do_reset();
    repeat (5) @(posedge clk);
    bus_xfer(1'b1, BASE + 32'h28, 4'hF, 32'h80, a1, a2, rd);
    bus_xfer(1'b1, BASE + 32'h18, 4'hF, 32'h80, a1, a2, rd);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL hold_irq: got %b want 0", irq); end
    bus_xfer(1'b0, BASE + 32'h20, 4'hF, 32'h0, a1, a2, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL hold_is: got %h want 0", rd); end
  endtask

  task automatic test_set_wins();
    @(negedge clk); gpio_in[7] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); gpio_in[7] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL first_rise_irq: got %b want 1", irq); end
    @(negedge clk); gpio_in[7] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); gpio_in[7] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    bus_xfer(1'b1, BASE + 32'h20, 4'hF, 32'h80, a1, a2, rd);
    bus_xfer(1'b0, BASE + 32'h20, 4'hF, 32'h0, a1, a2, rd);
    vectors++; if (rd !== 32'h80) begin miscompares++; $display("FAIL set_wins_is: got %h want 00000080", rd); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL set_wins_irq: got %b want 1", irq); end
  endtask

  task automatic test_byte_lanes();
    do_reset();
    bus_xfer(1'b1, BASE + 32'h00, 4'hF, 32'h1234_5600, a1, a2, rd);
    bus_xfer(1'b1, BASE + 32'h00, 4'b0010, 32'h0000_AB00, a1, a2, rd);
    vectors++; if (gpio_out[31:0] !== 32'h1234_AB00) begin miscompares++; $display("FAIL sel_0010: got %h want 1234ab00", gpio_out[31:0]); end
    bus_xfer(1'b1, BASE + 32'h00, 4'b0000, 32'hFFFF_FFFF, a1, a2, rd);
    vectors++; if (a1 !== 1'b1) begin miscompares++; $display("FAIL sel0_ack: got %b want 1", a1); end
    vectors++; if (gpio_out[31:0] !== 32'h1234_AB00) begin miscompares++; $display("FAIL sel0_nochg: got %h want 1234ab00", gpio_out[31:0]); end
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; wdat = 32'hFFFF_FFFF;
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ack: got %b want 0", ack); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ack2: got %b want 0", ack); end
    vectors++; if (gpio_out[31:0] !== 32'h0) begin miscompares++; $display("FAIL rst_mid_out: got %h want 0", gpio_out[31:0]); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h0C; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    vectors++; if (seen !== 4'b0101) begin miscompares++; $display("FAIL b2b_ack: got %b want 0101", seen); end
    @(posedge clk); #1;
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b want 0", ack); end
  endtask

  initial begin
    test_reset();
    test_write_out();
    test_read_map();
    test_edge_irq();
    test_reset_hold();
    test_set_wins();
    test_byte_lanes();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
